// File: rtl/hazard_scoreboard.sv
// ID-stage RAW hazard scoreboard: write delay line, per-register pending counters, stall and stall statistic.
// Optional macro HAZARD_WB_BYPASS_EN: the retiring write is treated as already visible (write-before-read).
module hazard_scoreboard #(
    parameter int WB_LATENCY  = 3,
    parameter int CNT_W       = 2,
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   id_valid,
    input  logic [1:0]             has_hazard,
    input  logic [1:0]             ra,
    input  logic [1:0]             rb,
    input  logic                   id_wr_en,
    input  logic [1:0]             id_rd,
    output logic                   stall,
    output logic [3:0]             busy,
    output logic [STALL_CNT_W-1:0] stall_cnt
);

    logic [WB_LATENCY-1:0] stg_v;
    logic [1:0]            stg_rd [WB_LATENCY];
    logic [CNT_W-1:0]      cnt    [4];
    logic [3:0]            pend;
    logic                  insert;
    logic                  retire;
    logic [1:0]            retire_rd;

    assign retire    = stg_v[WB_LATENCY-1];
    assign retire_rd = stg_rd[WB_LATENCY-1];
    assign insert    = id_valid & id_wr_en & ~stall;

    always_comb begin
        busy = '0;
        pend = '0;
        for (int unsigned r = 0; r < 4; r++) begin
            busy[r] = (cnt[r] != '0);
`ifdef HAZARD_WB_BYPASS_EN
            // The retiring write lands in the register file before this cycle's read.
            pend[r] = ((cnt[r] - CNT_W'(retire && (retire_rd == 2'(r)))) != '0);
`else
            pend[r] = (cnt[r] != '0);
`endif
        end
    end

    // Insert happens after this check, so an instruction never stalls on its own destination.
    assign stall = id_valid & ((has_hazard[1] & pend[ra]) | (has_hazard[0] & pend[rb]));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stg_v <= '0;
            for (int unsigned i = 0; i < WB_LATENCY; i++) begin
                stg_rd[i] <= '0;
            end
        end else begin
            stg_v[0]  <= insert;
            stg_rd[0] <= id_rd;
            for (int unsigned i = 1; i < WB_LATENCY; i++) begin
                stg_v[i]  <= stg_v[i-1];
                stg_rd[i] <= stg_rd[i-1];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned r = 0; r < 4; r++) begin
                cnt[r] <= '0;
            end
        end else begin
            for (int unsigned r = 0; r < 4; r++) begin
                if ((insert && id_rd == 2'(r)) && !(retire && retire_rd == 2'(r))) begin
                    cnt[r] <= cnt[r] + CNT_W'(1);
                end else if (!(insert && id_rd == 2'(r)) && (retire && retire_rd == 2'(r))) begin
                    cnt[r] <= cnt[r] - CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (stall && stall_cnt != '1) begin
            stall_cnt <= stall_cnt + STALL_CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard (WB_LATENCY=3); follows HAZARD_WB_BYPASS_EN when defined.
module tb_hazard_scoreboard;

    localparam int WB_LATENCY  = 3;
    localparam int CNT_W       = 2;
    localparam int STALL_CNT_W = 16;
`ifdef HAZARD_WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic                   clk = 1'b0;
    logic                   rst = 1'b1;
    logic                   id_valid = 1'b0;
    logic [1:0]             has_hazard = '0;
    logic [1:0]             ra = '0;
    logic [1:0]             rb = '0;
    logic                   id_wr_en = 1'b0;
    logic [1:0]             id_rd = '0;
    logic                   stall;
    logic [3:0]             busy;
    logic [STALL_CNT_W-1:0] stall_cnt;

    typedef struct packed {
        logic        s;
        logic [3:0]  b;
        logic [15:0] c;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    hazard_scoreboard #(
        .WB_LATENCY (WB_LATENCY),
        .CNT_W      (CNT_W),
        .STALL_CNT_W(STALL_CNT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .id_valid  (id_valid),
        .has_hazard(has_hazard),
        .ra        (ra),
        .rb        (rb),
        .id_wr_en  (id_wr_en),
        .id_rd     (id_rd),
        .stall     (stall),
        .busy      (busy),
        .stall_cnt (stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic compare_outputs(input string tag);
        exp_t e;
        if (exp_q.size() == 0) begin
            check({tag, ".queue_empty"}, 1, 0);
            return;
        end
        e = exp_q.pop_front();
        check({tag, ".stall"}, int'(stall), int'(e.s));
        check({tag, ".busy"}, int'(busy), int'(e.b));
        check({tag, ".stall_cnt"}, int'(stall_cnt), int'(e.c));
    endtask

    // One pipeline cycle: drive just after posedge, sample at negedge, return just after next posedge.
    task automatic cyc(input string tag, input logic v, input logic [1:0] hh, input logic [1:0] a,
                       input logic [1:0] b, input logic we, input logic [1:0] rd,
                       input logic es, input logic [3:0] eb, input int ec);
        id_valid = v; has_hazard = hh; ra = a; rb = b; id_wr_en = we; id_rd = rd;
        exp_q.push_back('{s: es, b: eb, c: 16'(ec)});
        @(negedge clk);
        compare_outputs(tag);
        @(posedge clk);
        #1;
    endtask

    // Asynchronous reset asserted mid-cycle with whatever is on the inputs; outputs must clear at once.
    task automatic rst_pulse(input string tag);
        rst = 1'b1;
        exp_q.push_back('{s: 1'b0, b: 4'b0000, c: 16'd0});
        #1;
        compare_outputs(tag);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input string tag, input logic [3:0] eb, input int ec);
        cyc(tag, 1'b0, 2'b00, 2'd0, 2'd0, 1'b0, 2'd0, 1'b0, eb, ec);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        @(posedge clk);
        #1;
        rst_pulse("init_rst");
        idle("post_rst", 4'b0000, 0);

        // RAW on A: write R1 in cycle 0, reader ra=1 held from cycle 1
        cyc("raw0", 1, 2'b00, 2'd0, 2'd0, 1, 2'd1, 0, 4'b0000, 0);
        cyc("raw1", 1, 2'b10, 2'd1, 2'd0, 0, 2'd0, 1, 4'b0010, 0);
        cyc("raw2", 1, 2'b10, 2'd1, 2'd0, 0, 2'd0, 1, 4'b0010, 1);
        cyc("raw3", 1, 2'b10, 2'd1, 2'd0, 0, 2'd0, !BYP, 4'b0010, 2);
        cyc("raw4", 1, 2'b10, 2'd1, 2'd0, 0, 2'd0, 0, 4'b0000, BYP ? 2 : 3);
        idle("raw5", 4'b0000, BYP ? 2 : 3);
        rst_pulse("raw_rst");

        // Operand mask; cycle 0 also reads its own destination without stalling
        cyc("msk0", 1, 2'b10, 2'd2, 2'd0, 1, 2'd2, 0, 4'b0000, 0);
        cyc("msk1", 1, 2'b01, 2'd2, 2'd0, 0, 2'd0, 0, 4'b0100, 0);
        cyc("msk2", 1, 2'b01, 2'd0, 2'd2, 0, 2'd0, 1, 4'b0100, 0);
        cyc("msk3", 1, 2'b00, 2'd2, 2'd2, 0, 2'd0, 0, 4'b0100, 1);
        idle("msk4", 4'b0000, 1);
        rst_pulse("msk_rst");

        // Concurrent insert/retire on R3
        cyc("cc0", 1, 2'b00, 2'd0, 2'd0, 1, 2'd3, 0, 4'b0000, 0);
        idle("cc1", 4'b1000, 0);
        idle("cc2", 4'b1000, 0);
        cyc("cc3", 1, 2'b00, 2'd0, 2'd0, 1, 2'd3, 0, 4'b1000, 0);
        idle("cc4", 4'b1000, 0);
        idle("cc5", 4'b1000, 0);
        idle("cc6", 4'b1000, 0);
        idle("cc7", 4'b0000, 0);
        rst_pulse("cc_rst");

        // Stalled writer: reads R0 (pending), writes R2 only once it issues
        cyc("sw0", 1, 2'b00, 2'd0, 2'd0, 1, 2'd0, 0, 4'b0000, 0);
        cyc("sw1", 1, 2'b10, 2'd0, 2'd0, 1, 2'd2, 1, 4'b0001, 0);
        cyc("sw2", 1, 2'b10, 2'd0, 2'd0, 1, 2'd2, 1, 4'b0001, 1);
        cyc("sw3", 1, 2'b10, 2'd0, 2'd0, 1, 2'd2, !BYP, 4'b0001, 2);
        cyc("sw4", !BYP, 2'b10, 2'd0, 2'd0, 1, 2'd2, 0, BYP ? 4'b0100 : 4'b0000, BYP ? 2 : 3);
        idle("sw5", 4'b0100, BYP ? 2 : 3);
        rst_pulse("sw_rst");

        // Mid-flight reset: write R1, reader in cycle 2, reset hits during cycle 2
        cyc("mf0", 1, 2'b00, 2'd0, 2'd0, 1, 2'd1, 0, 4'b0000, 0);
        idle("mf1", 4'b0010, 0);
        id_valid = 1; has_hazard = 2'b10; ra = 2'd1; id_wr_en = 0;
        #1;
        check("mf2.pre_rst_stall", int'(stall), 1);
        rst_pulse("mf2_rst");
        for (int i = 0; i < 5; i++) begin
            cyc($sformatf("mf_after%0d", i), 1, 2'b10, 2'd1, 2'd0, 0, 2'd0, 0, 4'b0000, 0);
        end

        check("queue_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Consumer side of the per-instruction operand-use decode: takes the 2-bit operand-read mask for the instruction in ID, plus its source and destination register indices.
- Tracks in-flight register writes from ID to writeback in a delay line with per-register pending counters.
- Produces the ID-stage stall, a per-register busy vector and a saturating stall statistic.
- Sits between the ID-stage control decode and the pipeline-register enables.

Parameters:
- WB_LATENCY, 3, cycles from ID issue of a write until it retires into the register file; minimum 1.
- CNT_W, 2, width of each pending counter; must hold WB_LATENCY (2^CNT_W - 1 >= WB_LATENCY).
- STALL_CNT_W, 16, width of the stall statistic counter.

Ports:
- clk  in  1  pipeline clock.
- rst  in  1  asynchronous reset, active-high.
- id_valid  in  1  an instruction is present in ID.
- has_hazard  in  2  operand-read mask; bit1 = reads ra, bit0 = reads rb.
- ra  in  2  source register A index.
- rb  in  2  source register B index.
- id_wr_en  in  1  the ID instruction writes a register.
- id_rd  in  2  destination register index.
- stall  out  1  hold IF/ID, inject bubble into ID/EX (combinational).
- busy  out  4  per-register pending flag (registered state, bit n = Rn).
- stall_cnt  out  STALL_CNT_W  saturating count of stall cycles.

Behaviour:
- Delay line: WB_LATENCY stages of {v, rd}. It shifts every cycle unconditionally and is not stalled by this block.
- Insert: stage0 loads {1, id_rd} when id_valid & id_wr_en & !stall. Otherwise stage0 loads {0, x}.
- Retire: the last stage, when valid, retires at the clock edge as it leaves.
- Counters: cnt[r] increments on insert to r and decrements on retire from r. Insert and retire to the same r at the same edge leave cnt[r] unchanged. No over- or underflow is possible given the parameter rule.
- busy[r] = (cnt[r] != 0).
- Effective pending pend(r) = cnt[r] != 0. This may be redefined by the optional feature.
- stall = id_valid & ((has_hazard[1] & pend(ra)) | (has_hazard[0] & pend(rb))).
- An unread operand never stalls, whatever its index.
- Latency: a write issued in cycle t is pending in cycles t+1 .. t+WB_LATENCY. A dependent instruction issues at t+WB_LATENCY+1 at the earliest.
- A stalled instruction inserts nothing. Its write is inserted in the cycle it finally issues.
- An instruction reading its own destination does not self-stall, because the insert happens after its check.
- stall_cnt increments each cycle stall = 1 and holds at all-ones.
- Reset (async, any time): all stage v = 0, cnt = 0, stall_cnt = 0.
  - busy = 0 and stall = 0 immediately while rst is high.
  - In-flight writes are discarded, with no deferred retire after release.

Optional Feature:
- Macro: HAZARD_WB_BYPASS_EN.
- Defined: the register file provides write-before-read in the retire cycle.
  - pend(r) = (cnt[r] - (last.v & last.rd == r)) != 0, i.e. the retiring entry is ignored.
  - The dependent instruction issues at t+WB_LATENCY.
  - busy is unchanged (raw counters).
- Undefined: pend(r) = cnt[r] != 0, as above.

Test Plan (WB_LATENCY=3):
- Reset: assert rst mid-stream -> busy=0000, stall=0, stall_cnt=0 immediately; still 0 after release with id_valid=0.
- RAW on A: cycle0 id_wr_en=1 id_rd=1; from cycle1 hold has_hazard=10 ra=1.
  - No bypass: stall=1 in cycles 1,2,3, issues cycle4, stall_cnt=3.
  - With HAZARD_WB_BYPASS_EN: stall in 1,2, issues cycle3, stall_cnt=2.
- Operand mask: R2 pending, has_hazard=01 ra=2 rb=0 -> stall=0; has_hazard=01 rb=2 -> stall=1; has_hazard=00 ra=rb=2 -> stall=0.
- Concurrent inc/dec: writes to R3 issued cycles 0 and 3 -> cnt[3]=1 after edges 0 and 3; busy[3]=1 cycles 1..6, 0 at cycle7.
- Stalled writer: R0 pending, ID instruction has_hazard=10 ra=0 id_wr_en=1 id_rd=2 -> stall=1, busy[2] stays 0 until the cycle after issue.
- Mid-flight reset: write R1 at cycle0, rst pulse in cycle2 -> busy[1]=0 at once, no retire side-effects, stall=0 for a following ra=1 reader.
